branch_sequencer: RTL

- Parametrised program-flow sequencer: owns the program counter and an internal return-address stack.
- Resolves jump, call and return opcodes, conditioned on the zero flag, fully inside the block. No push or pop leaves it for an external stack.
- Sits between instruction memory and the instruction decode path. Adds stall, halt, and stack overflow/underflow detection.

---
 rtl/branch_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// branch_sequencer: program-flow sequencer owning the PC and a private
// return-address stack. Resolves jump/call/return (optionally conditioned on
// the zero flag), stalls on en=0, and halts on OP_HALT or stack misuse.
//
// Build option: define BRANCH_SEQ_STACK_WRAP_EN to make the return stack
// circular (a call on a full stack overwrites the oldest entry instead of
// raising err_overflow and halting). Underflow handling is the same in both.
module branch_sequencer #(
    parameter int unsigned PC_WIDTH          = 5,
    parameter int unsigned OPCODE_WIDTH      = 6,
    parameter int unsigned INSTRUCTION_WIDTH = 40,
    parameter int unsigned STACK_DEPTH       = 4,
    parameter logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(6'h10),
    parameter logic [OPCODE_WIDTH-1:0] OP_JMP0 = OPCODE_WIDTH'(6'h11),
    parameter logic [OPCODE_WIDTH-1:0] OP_JMP1 = OPCODE_WIDTH'(6'h12),
    parameter logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(6'h13),
    parameter logic [OPCODE_WIDTH-1:0] OP_CAL0 = OPCODE_WIDTH'(6'h14),
    parameter logic [OPCODE_WIDTH-1:0] OP_CAL1 = OPCODE_WIDTH'(6'h15),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET  = OPCODE_WIDTH'(6'h16),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET0 = OPCODE_WIDTH'(6'h17),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET1 = OPCODE_WIDTH'(6'h18),
    parameter logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6'h3F)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [INSTRUCTION_WIDTH-1:0]         instr,
    input  logic                                 zero_flag,
    output logic [PC_WIDTH-1:0]                  pc,
    output logic                                 taken,
    output logic                                 pushed,
    output logic                                 popped,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
    output logic                                 err_overflow,
    output logic                                 err_underflow,
    output logic                                 halted
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    // Registered state
    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [PTR_W-1:0]      top_q, top_d;
    logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0]   stack_d [STACK_DEPTH];
    logic                  taken_q, taken_d;
    logic                  pushed_q, pushed_d;
    logic                  popped_q, popped_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  halted_q, halted_d;

    // Decode results
    logic [OPCODE_WIDTH-1:0] opcode_c;
    logic [PC_WIDTH-1:0]     target_c;
    logic                    is_jmp_c;
    logic                    is_call_c;
    logic                    is_ret_c;
    logic                    is_halt_c;
    logic                    cond_c;

    // Derived arithmetic
    logic [PC_WIDTH-1:0]     pc_inc_c;
    logic [PTR_W-1:0]        top_inc_c;
    logic [PTR_W-1:0]        top_dec_c;
    logic                    stack_full_c;
    logic                    stack_empty_c;

    // Only the opcode and target fields matter; the rest of the word is ignored
    logic unused_instr;
    assign unused_instr = ^instr;

    // Field extraction and opcode classification with condition evaluation
    always_comb begin
        opcode_c  = instr[32 +: OPCODE_WIDTH];
        target_c  = instr[24 +: PC_WIDTH];
        is_jmp_c  = 1'b0;
        is_call_c = 1'b0;
        is_ret_c  = 1'b0;
        is_halt_c = 1'b0;
        cond_c    = 1'b0;
        case (opcode_c)
            OP_JMP: begin
                is_jmp_c = 1'b1;
                cond_c   = 1'b1;
            end
            OP_JMP0: begin
                is_jmp_c = 1'b1;
                cond_c   = zero_flag;
            end
            OP_JMP1: begin
                is_jmp_c = 1'b1;
                cond_c   = ~zero_flag;
            end
            OP_CALL: begin
                is_call_c = 1'b1;
                cond_c    = 1'b1;
            end
            OP_CAL0: begin
                is_call_c = 1'b1;
                cond_c    = zero_flag;
            end
            OP_CAL1: begin
                is_call_c = 1'b1;
                cond_c    = ~zero_flag;
            end
            OP_RET: begin
                is_ret_c = 1'b1;
                cond_c   = 1'b1;
            end
            OP_RET0: begin
                is_ret_c = 1'b1;
                cond_c   = zero_flag;
            end
            OP_RET1: begin
                is_ret_c = 1'b1;
                cond_c   = ~zero_flag;
            end
            OP_HALT: begin
                is_halt_c = 1'b1;
            end
            default: begin
                cond_c = 1'b0;
            end
        endcase
    end

    // PC increment and circular stack pointer arithmetic
    always_comb begin
        pc_inc_c      = pc_q + PC_WIDTH'(1);
        top_inc_c     = (top_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
        top_dec_c     = (top_q == '0) ? PTR_W'(STACK_DEPTH - 1) : top_q - PTR_W'(1);
        stack_full_c  = (depth_q == DEPTH_W'(STACK_DEPTH));
        stack_empty_c = (depth_q == '0);
    end

    // Next-state, stack update and pulse generation
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        depth_d  = depth_q;
        top_d    = top_q;
        stack_d  = stack_q;
        taken_d  = 1'b0;
        pushed_d = 1'b0;
        popped_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            S_RUN: begin
                if (en) begin
                    if (is_halt_c) begin
                        state_d = S_HALT;
                    end else if (is_jmp_c && cond_c) begin
                        pc_d    = target_c;
                        taken_d = 1'b1;
                    end else if (is_call_c && cond_c) begin
                        if (!stack_full_c) begin
                            stack_d[top_q] = pc_inc_c;
                            top_d          = top_inc_c;
                            depth_d        = depth_q + DEPTH_W'(1);
                            pc_d           = target_c;
                            taken_d        = 1'b1;
                            pushed_d       = 1'b1;
                        end else begin
`ifdef BRANCH_SEQ_STACK_WRAP_EN
                            // Full ring: top_q points at the oldest slot
                            stack_d[top_q] = pc_inc_c;
                            top_d          = top_inc_c;
                            pc_d           = target_c;
                            taken_d        = 1'b1;
                            pushed_d       = 1'b1;
`else
                            ovf_d   = 1'b1;
                            state_d = S_HALT;
`endif
                        end
                    end else if (is_ret_c && cond_c) begin
                        if (!stack_empty_c) begin
                            pc_d     = stack_q[top_dec_c];
                            top_d    = top_dec_c;
                            depth_d  = depth_q - DEPTH_W'(1);
                            taken_d  = 1'b1;
                            popped_d = 1'b1;
                        end else begin
                            unf_d   = 1'b1;
                            state_d = S_HALT;
                        end
                    end else begin
                        pc_d = pc_inc_c;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        halted_d = (state_d == S_HALT);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= '0;
            depth_q  <= '0;
            top_q    <= '0;
            taken_q  <= 1'b0;
            pushed_q <= 1'b0;
            popped_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            top_q    <= top_d;
            taken_q  <= taken_d;
            pushed_q <= pushed_d;
            popped_q <= popped_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halted_q <= halted_d;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // Output mapping
    assign pc            = pc_q;
    assign taken         = taken_q;
    assign pushed        = pushed_q;
    assign popped        = popped_q;
    assign depth         = depth_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign halted        = halted_q;

endmodule
